// File: rtl/pinaipple_periph_fabric.sv
// pinaipple_periph_fabric: single-host data-bus fabric with address decode, external slot routing and an internal GPIO device.
// Host side: host_req_i/host_gnt_o request handshake, host_addr_i/we/be/wdata request fields,
//   host_rvalid_o/host_rdata_o/host_err_o single-beat response (rdata is zero whenever rvalid is low).
// Device side: dev_req_o/dev_ready_i per-slot valid/ready (0 Ram, 1 Uart, 2 Timer, 3 Fraise, 4 SimCtrl),
//   shared dev_addr_o (slot-relative offset)/dev_we_o/dev_be_o/dev_wdata_o, per-slot dev_rvalid_i/dev_rdata_i.
// GPIO: gp_o driven by the GPO register, gp_i sampled through a two-flop synchronizer.
// Optional BUS_TIMEOUT_EN: external slots that stay silent for 255 WAIT cycles get an error response.
module pinaipple_periph_fabric #(
  parameter int GPIWidth       = 8,
  parameter int GPOWidth       = 8,
  parameter int ADDR_DEV_WIDTH = 20,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                           clk_sys_in,
  input  logic                           rst_sys_in,
  input  logic                           host_req_i,
  output logic                           host_gnt_o,
  input  logic [31:0]                    host_addr_i,
  input  logic                           host_we_i,
  input  logic [3:0]                     host_be_i,
  input  logic [DATA_WIDTH-1:0]          host_wdata_i,
  output logic                           host_rvalid_o,
  output logic [DATA_WIDTH-1:0]          host_rdata_o,
  output logic                           host_err_o,
  output logic [4:0]                     dev_req_o,
  input  logic [4:0]                     dev_ready_i,
  output logic [ADDR_DEV_WIDTH-1:0]      dev_addr_o,
  output logic                           dev_we_o,
  output logic [3:0]                     dev_be_o,
  output logic [DATA_WIDTH-1:0]          dev_wdata_o,
  input  logic [4:0]                     dev_rvalid_i,
  input  logic [4:0][DATA_WIDTH-1:0]     dev_rdata_i,
  input  logic [GPIWidth-1:0]            gp_i,
  output logic [GPOWidth-1:0]            gp_o
);
  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
  // Targets 0..4 are the external slot indices; GPIO and ERR sit above them.
  localparam logic [2:0] T_GPIO = 3'd5;
  localparam logic [2:0] T_ERR  = 3'd6;
  state_e                state_q, state_d;
  logic [2:0]            sel, tgt_q, tgt_d;
  logic [31:0]           base;
  logic                  sel_ext, tgt_ext, resp, timeout, accept, gpio_hit, gpo_wr;
  logic [DATA_WIDTH-1:0] gpio_rd, gpio_rdata_q;
  logic [GPOWidth-1:0]   gpo_q, gpo_d;
  logic [GPIWidth-1:0]   gpi_meta_q, gpi_q;

  always_comb begin
    sel  = T_ERR;
    base = '0;
    if ((host_addr_i & ~32'h0000_03ff) == 32'h0002_0000) begin
      sel  = 3'd4;
      base = 32'h0002_0000;
    end else if ((host_addr_i & ~32'h0000_ffff) == 32'h0010_0000) begin
      sel  = 3'd0;
      base = 32'h0010_0000;
    end else if ((host_addr_i & ~32'h0000_0fff) == 32'h8000_0000) begin
      sel  = T_GPIO;
      base = 32'h8000_0000;
    end else if ((host_addr_i & ~32'h0000_0fff) == 32'h8000_1000) begin
      sel  = 3'd1;
      base = 32'h8000_1000;
    end else if ((host_addr_i & ~32'h0000_0fff) == 32'h8000_2000) begin
      sel  = 3'd2;
      base = 32'h8000_2000;
    end else if ((host_addr_i & ~32'h0000_0fff) == 32'h8000_3000) begin
      sel  = 3'd3;
      base = 32'h8000_3000;
    end
  end

  assign sel_ext = sel < 3'd5;
  assign tgt_ext = tgt_q < 3'd5;
  // resp marks the cycle the outstanding transaction completes; that cycle also accepts a new request.
  assign resp    = (state_q == ST_WAIT) && (tgt_ext ? (dev_rvalid_i[tgt_q] | timeout) : 1'b1);
  // Gating with reset keeps gnt/req low while reset is held, as the state register alone would not.
  assign accept  = rst_sys_in && ((state_q == ST_IDLE) || resp);

  assign host_gnt_o    = accept && host_req_i && (sel_ext ? dev_ready_i[sel] : 1'b1);
  assign dev_req_o     = (accept && host_req_i && sel_ext) ? (5'b00001 << sel) : 5'b00000;
  assign dev_addr_o    = ADDR_DEV_WIDTH'(host_addr_i - base);
  assign dev_we_o      = host_we_i;
  assign dev_be_o      = host_be_i;
  assign dev_wdata_o   = host_wdata_i;
  assign host_rvalid_o = resp;
  assign host_err_o    = resp && ((tgt_q == T_ERR) || timeout);
  assign host_rdata_o  = (!resp || timeout) ? '0 : tgt_ext ? dev_rdata_i[tgt_q] : (tgt_q == T_GPIO) ? gpio_rdata_q : '0;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) cnt_q <= '0;
    else cnt_q <= ((state_q == ST_IDLE) || resp) ? 8'd0 : cnt_q + 8'd1;
  end
  // A response arriving in the very last cycle still wins over the timeout.
  assign timeout = (state_q == ST_WAIT) && tgt_ext && (cnt_q == 8'hff) && !dev_rvalid_i[tgt_q];
`else
  assign timeout = 1'b0;
`endif

  assign state_d = host_gnt_o ? ST_WAIT : resp ? ST_IDLE : state_q;
  assign tgt_d   = host_gnt_o ? sel : tgt_q;

  // GPIO acts at grant: writes land immediately and read data is captured for the following response cycle.
  assign gpio_hit = host_gnt_o && (sel == T_GPIO);
  assign gpo_wr   = gpio_hit && host_we_i && (host_addr_i[11:0] == 12'h000);
  assign gpio_rd  = host_we_i ? '0 : (host_addr_i[11:0] == 12'h000) ? DATA_WIDTH'(gpo_q) : (host_addr_i[11:0] == 12'h004) ? DATA_WIDTH'(gpi_q) : '0;

  for (genvar i = 0; i < GPOWidth; i++) begin : g_gpo
    assign gpo_d[i] = (gpo_wr && host_be_i[i/8]) ? host_wdata_i[i] : gpo_q[i];
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      state_q      <= ST_IDLE;
      tgt_q        <= T_ERR;
      gpo_q        <= '0;
      gpi_meta_q   <= '0;
      gpi_q        <= '0;
      gpio_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      gpo_q        <= gpo_d;
      gpi_meta_q   <= gp_i;
      gpi_q        <= gpi_meta_q;
      gpio_rdata_q <= gpio_hit ? gpio_rd : gpio_rdata_q;
    end
  end

  assign gp_o = gpo_q;
endmodule

// File: tb/tb_pinaipple_periph_fabric.sv
// tb_pinaipple_periph_fabric: randomized self-checking bench for pinaipple_periph_fabric against a behavioural address-map/GPIO model.
module tb_pinaipple_periph_fabric;
  logic             clk_sys_in = 1'b0;
  logic             rst_sys_in = 1'b0;
  logic             host_req_i = 1'b0;
  logic             host_gnt_o;
  logic [31:0]      host_addr_i = '0;
  logic             host_we_i = 1'b0;
  logic [3:0]       host_be_i = '0;
  logic [31:0]      host_wdata_i = '0;
  logic             host_rvalid_o;
  logic [31:0]      host_rdata_o;
  logic             host_err_o;
  logic [4:0]       dev_req_o;
  logic [4:0]       dev_ready_i = '0;
  logic [19:0]      dev_addr_o;
  logic             dev_we_o;
  logic [3:0]       dev_be_o;
  logic [31:0]      dev_wdata_o;
  logic [4:0]       dev_rvalid_i = '0;
  logic [4:0][31:0] dev_rdata_i = '0;
  logic [7:0]       gp_i = '0;
  logic [7:0]       gp_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_gpo = '0;

  // Regions 0..4 are the external slots by dev index, 5 is GPIO; anything else is unmapped.
  logic [31:0] reg_base [6] = '{32'h0010_0000, 32'h8000_1000, 32'h8000_2000, 32'h8000_3000, 32'h0002_0000, 32'h8000_0000};
  logic [31:0] reg_size [6] = '{32'h0001_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_0400, 32'h0000_1000};

  pinaipple_periph_fabric dut (
    .clk_sys_in(clk_sys_in), .rst_sys_in(rst_sys_in),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_ready_i(dev_ready_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
    .gp_i(gp_i), .gp_o(gp_o)
  );

  always #5 clk_sys_in = ~clk_sys_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    for (int i = 0; i < 6; i++)
      if (a >= reg_base[i] && a - reg_base[i] < reg_size[i]) return i;
    return 6;
  endfunction

  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                     input int rdy_dly, input int rsp_dly, input logic [31:0] dev_val);
    int s;
    logic [31:0] exp_rd;
    s = region(a);
    if (s < 5) exp_rd = dev_val;
    else if (s == 6 || we) exp_rd = 0;
    else exp_rd = (a[11:0] == 12'h000) ? {24'h0, exp_gpo} : (a[11:0] == 12'h004) ? {24'h0, gp_i} : 32'h0;
    @(negedge clk_sys_in);
    host_req_i = 1; host_addr_i = a; host_we_i = we; host_be_i = be; host_wdata_i = wd;
    if (s < 5) begin
      for (int k = 0; k < rdy_dly; k++) begin
        dev_ready_i = 5'($urandom) & ~(5'b1 << s);
        #1;
        check("gnt_stall", {31'h0, host_gnt_o}, 0);
        check("req_stall", {27'h0, dev_req_o}, 32'(5'b1 << s));
        @(negedge clk_sys_in);
      end
      dev_ready_i = 5'b1 << s;
      #1;
      check("gnt", {31'h0, host_gnt_o}, 1);
      check("req", {27'h0, dev_req_o}, 32'(5'b1 << s));
      check("dev_addr", {12'h0, dev_addr_o}, (a - reg_base[s]) & 32'h000f_ffff);
      check("dev_fields", {dev_we_o, dev_be_o}, {27'h0, we, be});
      check("dev_wdata", dev_wdata_o, wd);
    end else begin
      dev_ready_i = 5'($urandom);
      #1;
      check("gnt_local", {31'h0, host_gnt_o}, 1);
      check("req_local", {27'h0, dev_req_o}, 0);
      if (s == 5 && we && a[11:0] == 12'h000)
        for (int b = 0; b < 8; b++) if (be[0]) exp_gpo[b] = wd[b];
    end
    @(negedge clk_sys_in);
    host_req_i = 0; dev_ready_i = 0;
    if (s < 5) begin
      for (int k = 0; k < rsp_dly; k++) begin
        dev_rvalid_i = 5'($urandom) & ~(5'b1 << s);
        #1;
        check("rvalid_wait", {31'h0, host_rvalid_o}, 0);
        check("rdata_idle", host_rdata_o, 0);
        check("req_wait", {27'h0, dev_req_o}, 0);
        @(negedge clk_sys_in);
      end
      dev_rvalid_i = (5'b1 << s) | 5'($urandom);
      dev_rdata_i[s] = dev_val;
    end
    #1;
    check("rvalid", {31'h0, host_rvalid_o}, 1);
    check("rdata", host_rdata_o, exp_rd);
    check("err", {31'h0, host_err_o}, (s == 6) ? 1 : 0);
    check("gp_o", {24'h0, gp_o}, {24'h0, exp_gpo});
    @(negedge clk_sys_in);
    dev_rvalid_i = 0;
    #1;
    check("rvalid_drop", {31'h0, host_rvalid_o}, 0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    host_req_i = 1; host_addr_i = 32'h8000_0000;
    repeat (3) @(negedge clk_sys_in);
    #1;
    check("rst_gnt", {31'h0, host_gnt_o}, 0);
    check("rst_req", {27'h0, dev_req_o}, 0);
    check("rst_rsp", {host_rvalid_o, host_err_o}, 0);
    check("rst_rdata", host_rdata_o, 0);
    check("rst_gp_o", {24'h0, gp_o}, 0);
    host_req_i = 0;
    @(negedge clk_sys_in);
    rst_sys_in = 1;

    txn(32'h8000_0000, 1, 4'b0001, 32'h0000_00A5, 0, 0, 0);
    txn(32'h8000_0000, 0, 4'b1111, 0, 0, 0, 0);
    check("gpo_a5", {24'h0, gp_o}, 32'hA5);
    gp_i = 8'h3C;
    repeat (3) @(negedge clk_sys_in);
    txn(32'h8000_0004, 0, 4'b1111, 0, 0, 0, 0);
    txn(32'h0010_0010, 0, 4'b1111, 0, 2, 0, 32'hDEAD_BEEF);
    txn(32'h4000_0000, 0, 4'b1111, 0, 0, 0, 0);
    txn(32'h8000_0000, 1, 4'b1110, 32'hFFFF_FF00, 0, 0, 0);
    txn(32'h8000_0008, 1, 4'b1111, 32'h1234_5678, 0, 0, 0);
    txn(32'h8000_0008, 0, 4'b1111, 0, 0, 0, 0);

    // Back-to-back: Timer read, UART write granted in the Timer response cycle.
    @(negedge clk_sys_in);
    host_req_i = 1; host_addr_i = 32'h8000_2008; host_we_i = 0; dev_ready_i = 5'b00100;
    #1;
    check("b2b_gnt_t", {31'h0, host_gnt_o}, 1);
    check("b2b_addr_t", {12'h0, dev_addr_o}, 32'h008);
    @(negedge clk_sys_in);
    host_req_i = 0; dev_ready_i = 0; dev_rvalid_i = 5'b00010; dev_rdata_i[1] = 32'hBAD0_BAD0;
    #1;
    check("b2b_stray", {31'h0, host_rvalid_o}, 0);
    @(negedge clk_sys_in);
    dev_rvalid_i = 5'b00100; dev_rdata_i[2] = 32'h7111_E700;
    host_req_i = 1; host_addr_i = 32'h8000_1004; host_we_i = 1; host_wdata_i = 32'h55; dev_ready_i = 5'b00010;
    #1;
    check("b2b_rv_t", {31'h0, host_rvalid_o}, 1);
    check("b2b_rd_t", host_rdata_o, 32'h7111_E700);
    check("b2b_gnt_u", {31'h0, host_gnt_o}, 1);
    check("b2b_req_u", {27'h0, dev_req_o}, 32'h2);
    check("b2b_addr_u", {12'h0, dev_addr_o}, 32'h004);
    @(negedge clk_sys_in);
    host_req_i = 0; host_we_i = 0; dev_ready_i = 0; dev_rvalid_i = 5'b00010; dev_rdata_i[1] = 32'h0000_0C0D;
    #1;
    check("b2b_rv_u", {31'h0, host_rvalid_o}, 1);
    check("b2b_rd_u", host_rdata_o, 32'h0000_0C0D);
    check("b2b_err_u", {31'h0, host_err_o}, 0);
    @(negedge clk_sys_in);
    dev_rvalid_i = 0;
    #1;
    check("b2b_idle", {31'h0, host_rvalid_o}, 0);

    // Reset while a RAM read is outstanding: no response, late rvalid ignored.
    @(negedge clk_sys_in);
    host_req_i = 1; host_addr_i = 32'h0010_0000; dev_ready_i = 5'b00001;
    #1;
    check("mr_gnt", {31'h0, host_gnt_o}, 1);
    @(negedge clk_sys_in);
    host_req_i = 0; dev_ready_i = 0; rst_sys_in = 0;
    #1;
    check("mr_rv", {31'h0, host_rvalid_o}, 0);
    exp_gpo = 0;
    @(negedge clk_sys_in);
    rst_sys_in = 1; dev_rvalid_i = 5'b00001; dev_rdata_i[0] = 32'hFEED_0001;
    #1;
    check("mr_late", {31'h0, host_rvalid_o}, 0);
    check("mr_rdata", host_rdata_o, 0);
    check("mr_gp_o", {24'h0, gp_o}, 0);
    @(negedge clk_sys_in);
    dev_rvalid_i = 0;

`ifdef BUS_TIMEOUT_EN
    begin
      int n;
      @(negedge clk_sys_in);
      host_req_i = 1; host_addr_i = 32'h8000_3000; dev_ready_i = 5'b01000;
      #1;
      check("to_gnt", {31'h0, host_gnt_o}, 1);
      @(negedge clk_sys_in);
      host_req_i = 0; dev_ready_i = 0;
      n = 0;
      #1;
      while (!host_rvalid_o && n < 300) begin
        @(negedge clk_sys_in);
        #1;
        n++;
      end
      check("to_cycles", n, 255);
      check("to_err", {31'h0, host_err_o}, 1);
      check("to_rdata", host_rdata_o, 0);
      @(negedge clk_sys_in);
      dev_rvalid_i = 5'b01000;
      #1;
      check("to_late", {31'h0, host_rvalid_o}, 0);
      @(negedge clk_sys_in);
      dev_rvalid_i = 0;
    end
`endif

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 7);
      if (r < 5) a = reg_base[r] + ($urandom_range(0, reg_size[r] - 1) & ~32'h3);
      else if (r == 5) begin
        case ($urandom_range(0, 3))
          0: a = 32'h8000_0000;
          1: a = 32'h8000_0004;
          2: a = 32'h8000_0008;
          default: a = 32'h8000_0ffc;
        endcase
      end else a = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        gp_i = 8'($urandom);
        repeat (3) @(negedge clk_sys_in);
      end
      txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
